// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the UART boot loader
package boot_pkg;

  typedef enum logic [2:0] {
    RESET_EXIT,
    WAIT_MAGIC,
    LEN,
    DATA,
    CHECK,
    ACK,
    NAK,
    DONE
  } boot_state_e;

  typedef enum logic [1:0] {
    F_POLL,
    F_POP,
    F_GAP
  } fetch_state_e;

  localparam logic [7:0] BOOT_MAGIC = 8'hB0;
  localparam logic [7:0] BOOT_ACK   = 8'h06;
  localparam logic [7:0] BOOT_NAK   = 8'h15;

  localparam logic [1:0] UART_REG_BAUD   = 2'b00;
  localparam logic [1:0] UART_REG_STATUS = 2'b01;
  localparam logic [1:0] UART_REG_RXDATA = 2'b10;
  localparam logic [1:0] UART_REG_TXDATA = 2'b11;

  // Little-endian accumulation: the newest byte enters at the top.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// rtl/uart_byte_fetch.sv - polls UART status and pops one RX byte at a time
module uart_byte_fetch
  import boot_pkg::*;
#(
  parameter int BusDataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [BusDataWidth-1:0] bus_rdata_i,
  output logic [1:0]              offset_o,
  output logic [7:0]              byte_o,
  output logic                    byte_vld_o
);

  fetch_state_e state, state_d;
  logic         unused_rdata;

  assign unused_rdata = ^bus_rdata_i[BusDataWidth-1:8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= F_POLL;
      byte_o     <= 8'h00;
      byte_vld_o <= 1'b0;
    end else begin
      state      <= state_d;
      byte_vld_o <= (state == F_POP);
      if (state == F_POP) begin
        byte_o <= bus_rdata_i[7:0];
      end
    end
  end

  // The gap cycle lets the consumer react to byte_vld before the next poll,
  // so a state change (e.g. into ACK) never races a fresh pop.
  always_comb begin
    state_d  = state;
    offset_o = UART_REG_STATUS;
    case (state)
      F_POLL: begin
        if (req_i && bus_rdata_i[0]) begin
          state_d = F_POP;
        end
      end
      F_POP: begin
        offset_o = UART_REG_RXDATA;
        state_d  = F_GAP;
      end
      F_GAP:   state_d = F_POLL;
      default: state_d = F_POLL;
    endcase
  end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a framed program image over UART into IMEM and releases the core
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int                    BusDataWidth  = 32,
  parameter int                    ImemAddrWidth = 12,
  parameter logic [BusDataWidth-1:0] UartBase    = '0,
  parameter int unsigned           TimeoutCycles = 5_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     boot_en_i,
  output logic                     bus_wr_en_o,
  output logic [BusDataWidth-1:0]  bus_addr_o,
  output logic [BusDataWidth-1:0]  bus_wdata_o,
  input  logic [BusDataWidth-1:0]  bus_rdata_i,
  output logic                     imem_we_o,
  output logic [ImemAddrWidth-1:0] imem_addr_o,
  output logic [BusDataWidth-1:0]  imem_wdata_o,
  output logic                     cpu_rst_o,
  output logic                     done_o,
  output logic                     error_o
);

  localparam int          Bytes    = BusDataWidth / 8;
  localparam int          IdxW     = $clog2(Bytes);
  localparam int          CntW     = ImemAddrWidth + 1;
  localparam logic [31:0] MaxWords = 32'(1) << ImemAddrWidth;

  boot_state_e             state, state_d;
  logic [1:0]              fetch_off, off;
  logic [7:0]              rx_byte;
  logic                    byte_vld;
  logic                    req;
  logic [IdxW-1:0]         byte_idx;
  logic [31:0]             len_q, len_full;
  logic [BusDataWidth-1:0] word_q, word_full;
  logic [7:0]              chk;
  logic [CntW-1:0]         word_cnt;
  logic [31:0]             tmo_cnt;
  logic                    tmo_active, tmo_hit, tmo_fire;
  logic                    word_last, words_done, len_bad;
  logic                    unused_len;

  uart_byte_fetch #(.BusDataWidth(BusDataWidth)) u_fetch (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req),
    .bus_rdata_i(bus_rdata_i),
    .offset_o   (fetch_off),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld)
  );

  assign len_full   = shift_in_byte(len_q, rx_byte);
  assign len_bad    = (len_full == 32'd0) || (len_full > MaxWords);
  assign word_full  = {rx_byte, word_q[BusDataWidth-1:8]};
  assign word_last  = (byte_idx == IdxW'(Bytes - 1));
  assign words_done = ((word_cnt + CntW'(1)) == len_q[CntW-1:0]);
  assign unused_len = ^len_q[31:CntW];

  assign tmo_active = ((state == LEN) || (state == DATA) || (state == CHECK)) && (TimeoutCycles != 0);
  assign tmo_hit    = tmo_active && (tmo_cnt >= TimeoutCycles);
  // Expiry is held off while a byte is visible or about to be popped: the byte wins.
  assign tmo_fire   = tmo_hit && !byte_vld && (fetch_off == UART_REG_STATUS) && !bus_rdata_i[0];

  always_comb begin
    state_d     = state;
    req         = 1'b0;
    bus_wr_en_o = 1'b0;
    bus_wdata_o = '0;
    off         = fetch_off;
    case (state)
      RESET_EXIT: state_d = boot_en_i ? WAIT_MAGIC : DONE;
      WAIT_MAGIC: begin
        req = 1'b1;
        if (byte_vld && (rx_byte == BOOT_MAGIC)) state_d = LEN;
      end
      LEN: begin
        req = 1'b1;
        if (byte_vld) begin
          if (byte_idx[1:0] == 2'b11) state_d = len_bad ? NAK : DATA;
        end else if (tmo_fire) begin
          state_d = NAK;
        end
      end
      DATA: begin
        req = 1'b1;
        if (byte_vld) begin
          if (word_last && words_done) state_d = CHECK;
        end else if (tmo_fire) begin
          state_d = NAK;
        end
      end
      CHECK: begin
        req = 1'b1;
        if (byte_vld) begin
          state_d = (rx_byte == chk) ? ACK : NAK;
        end else if (tmo_fire) begin
          state_d = NAK;
        end
      end
      ACK: begin
        bus_wr_en_o = 1'b1;
        off         = UART_REG_TXDATA;
        bus_wdata_o = BusDataWidth'(BOOT_ACK);
        state_d     = DONE;
      end
      NAK: begin
        bus_wr_en_o = 1'b1;
        off         = UART_REG_TXDATA;
        bus_wdata_o = BusDataWidth'(BOOT_NAK);
        state_d     = WAIT_MAGIC;
      end
      DONE:    state_d = DONE;
      default: state_d = RESET_EXIT;
    endcase
  end

  assign bus_addr_o = UartBase | BusDataWidth'(off);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RESET_EXIT;
      byte_idx     <= '0;
      len_q        <= '0;
      word_q       <= '0;
      chk          <= 8'h00;
      word_cnt     <= '0;
      tmo_cnt      <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rst_o    <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state     <= state_d;
      imem_we_o <= 1'b0;

      if (byte_vld || !tmo_active) begin
        tmo_cnt <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (state_d == DONE) begin
        cpu_rst_o <= 1'b0;
        done_o    <= 1'b1;
      end

      if (state == NAK) error_o <= 1'b1;

      if (byte_vld) begin
        case (state)
          WAIT_MAGIC: begin
            if (rx_byte == BOOT_MAGIC) begin
              error_o  <= 1'b0;
              chk      <= 8'h00;
              word_cnt <= '0;
              byte_idx <= '0;
            end
          end
          LEN: begin
            len_q    <= len_full;
            byte_idx <= (byte_idx[1:0] == 2'b11) ? '0 : byte_idx + IdxW'(1);
          end
          DATA: begin
            word_q   <= word_full;
            chk      <= chk ^ rx_byte;
            byte_idx <= byte_idx + IdxW'(1);
            if (word_last) begin
              imem_we_o    <= 1'b1;
              imem_addr_o  <= word_cnt[ImemAddrWidth-1:0];
              imem_wdata_o <= word_full;
              word_cnt     <= word_cnt + CntW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench: UART RX FIFO model, IMEM/TX event checking
module tb_uart_boot_loader;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          boot_en_i = 1'b0;
  logic          bus_wr_en_o;
  logic [DW-1:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_wdata_o;
  logic          cpu_rst_o, done_o, error_o;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_cnt  = 0;
  int acc_hi  = 0;

  logic [7:0]     rx_mem [0:255];
  int             wr_ptr = 0;
  int             rd_ptr = 0;
  logic [7:0]     exp_tx[$];
  logic [43:0]    exp_imem[$];
  logic [7:0]     f[$];

  uart_boot_loader #(
    .BusDataWidth (DW),
    .ImemAddrWidth(AW),
    .UartBase     (32'h0),
    .TimeoutCycles(100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .boot_en_i   (boot_en_i),
    .bus_wr_en_o (bus_wr_en_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .cpu_rst_o   (cpu_rst_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART register model: combinational reads, RX pop on each offset-10 cycle
  always_comb begin
    case (bus_addr_o[1:0])
      2'b01:   bus_rdata_i = {31'b0, (rd_ptr != wr_ptr)};
      2'b10:   bus_rdata_i = {24'b0, rx_mem[rd_ptr & 255]};
      default: bus_rdata_i = '0;
    endcase
  end

  always @(posedge clk_i) begin
    if (!rst_i && bus_addr_o[1:0] == 2'b10) begin
      check("rx_pop_nonempty", 128'(rd_ptr != wr_ptr), 128'd1);
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a bus write or IMEM write
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus_addr_o[1:0] == 2'b00 || bus_addr_o[31:2] != 30'd0) begin
        check("bus_addr_legal", 128'(bus_addr_o), 128'd1);
      end
      if (bus_addr_o[1]) acc_hi++;
      if (bus_wr_en_o) begin
        tx_cnt++;
        check("tx_expected", 128'(exp_tx.size() > 0), 128'd1);
        if (exp_tx.size() > 0) begin
          check("tx_write", {64'b0, bus_addr_o, bus_wdata_o}, {64'b0, 32'h3, 24'h0, exp_tx.pop_front()});
        end
      end
      if (imem_we_o) begin
        check("imem_expected", 128'(exp_imem.size() > 0), 128'd1);
        if (exp_imem.size() > 0) begin
          check("imem_write", {84'b0, imem_addr_o, imem_wdata_o}, {84'b0, exp_imem.pop_front()});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name,
          {15'b0, bus_wr_en_o, bus_addr_o, bus_wdata_o, imem_we_o, imem_addr_o, imem_wdata_o,
           cpu_rst_o, done_o, error_o},
          {15'b0, 1'b0, 32'h1, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk_i);
    rst_i     = 1'b1;
    boot_en_i = en;
    repeat (2) @(posedge clk_i);
    #1;
    wr_ptr = rd_ptr;
    exp_tx.delete();
    exp_imem.delete();
    check_reset_outputs("reset_outputs");
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] b[$]);
    foreach (b[i]) begin
      rx_mem[wr_ptr & 255] = b[i];
      wr_ptr++;
    end
  endtask

  // kind 0: done_o; 1: error_o==val; 2: tx_cnt>=val; 3: IMEM scoreboard drained
  task automatic wait_for(input int kind, input int val, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk_i);
      case (kind)
        0:       ok = done_o;
        1:       ok = (error_o == val[0]);
        2:       ok = (tx_cnt >= val);
        default: ok = (exp_imem.size() == 0);
      endcase
    end
    check({"wait_", name}, 128'(ok), 128'd1);
  endtask

  task automatic end_check(input string name);
    repeat (3) @(negedge clk_i);
    check({name, "_scoreboard_empty"}, 128'(exp_tx.size() + exp_imem.size()), 128'd0);
    check({name, "_rx_all_popped"}, 128'(rd_ptr), 128'(wr_ptr));
  endtask

  initial begin
    int base;

    // 1: boot disabled
    do_reset(1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    check("t1_released", {126'b0, cpu_rst_o, done_o}, {126'b0, 1'b0, 1'b1});
    repeat (10) @(negedge clk_i);
    check("t1_no_rx_tx_access", 128'(acc_hi), 128'd0);

    // 2: two-word image
    do_reset(1'b1);
    exp_imem.push_back({12'h0, 32'h00000013});
    exp_imem.push_back({12'h1, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    f = '{8'hB0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
    push(f);
    wait_for(0, 0, "t2_done");
    check("t2_final", {125'b0, cpu_rst_o, done_o, error_o}, {125'b0, 1'b0, 1'b1, 1'b0});
    end_check("t2");

    // 3: bad checksum then resend
    do_reset(1'b1);
    exp_imem.push_back({12'h0, 32'h00000013});
    exp_imem.push_back({12'h1, 32'hDEADBEEF});
    exp_tx.push_back(8'h15);
    f[13] = 8'h30;
    push(f);
    wait_for(1, 1, "t3_error_set");
    check("t3_after_nak", {125'b0, cpu_rst_o, done_o, error_o}, {125'b0, 1'b1, 1'b0, 1'b1});
    exp_imem.push_back({12'h0, 32'h00000013});
    exp_imem.push_back({12'h1, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    f[13] = 8'h31;
    push(f);
    wait_for(1, 0, "t3_error_clear");
    check("t3_clear_before_done", 128'(done_o), 128'd0);
    wait_for(0, 0, "t3_done");
    check("t3_final", {125'b0, cpu_rst_o, done_o, error_o}, {125'b0, 1'b0, 1'b1, 1'b0});
    end_check("t3");

    // 4: leading junk, one-word frame
    do_reset(1'b1);
    exp_imem.push_back({12'h0, 32'h12345678});
    exp_tx.push_back(8'h06);
    f = '{8'h55, 8'hAA, 8'h00, 8'hB0, 8'h01, 8'h00, 8'h00, 8'h00,
          8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    push(f);
    wait_for(0, 0, "t4_done");
    end_check("t4");

    // 5: LEN=0 and LEN=MaxWords+1
    do_reset(1'b1);
    base = tx_cnt;
    exp_tx.push_back(8'h15);
    f = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'h00};
    push(f);
    wait_for(2, base + 1, "t5_nak_len0");
    exp_tx.push_back(8'h15);
    f = '{8'hB0, 8'h01, 8'h10, 8'h00, 8'h00};
    push(f);
    wait_for(2, base + 2, "t5_nak_len_big");
    repeat (2) @(negedge clk_i);
    check("t5_state", {125'b0, cpu_rst_o, done_o, error_o}, {125'b0, 1'b1, 1'b0, 1'b1});
    end_check("t5");

    // 6a: stall after two payload bytes
    do_reset(1'b1);
    base = tx_cnt;
    exp_tx.push_back(8'h15);
    f = '{8'hB0, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    push(f);
    wait_for(2, base + 1, "t6_timeout_nak");
    repeat (2) @(negedge clk_i);
    check("t6_after_timeout", {125'b0, cpu_rst_o, done_o, error_o}, {125'b0, 1'b1, 1'b0, 1'b1});
    end_check("t6a");

    // 6b: asynchronous reset in the middle of DATA
    do_reset(1'b1);
    exp_imem.push_back({12'h0, 32'h44332211});
    f = '{8'hB0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push(f);
    wait_for(3, 0, "t6_first_word");
    repeat (3) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    do_reset(1'b1);
    end_check("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
